// File: rtl/ps2_mouse_multi.sv
// rtl/ps2_mouse_multi.sv - NUM_MICE independent PS/2 mouse receivers with clamped cursors
//
// Purpose: per channel, decode 11-bit PS/2 frames into 3-byte standard mouse
//          packets, accumulate a cursor clamped to the canvas, report buttons,
//          left-click rising-edge pulses, packet-accepted and error pulses.
// Optional: define MOUSE_ACCEL_EN to double deltas with |d| >= 8; this adds one
//           pipeline stage (latency 5 instead of 4 clk_in cycles).
// Ports:
//   clk_in    - system clock
//   rst_in    - synchronous active-high reset
//   ps2_clk   - raw PS/2 clock per channel (asynchronous)
//   ps2_data  - raw PS/2 data per channel (asynchronous)
//   mouse_x   - packed cursor x, channel i at [i*XW +: XW]
//   mouse_y   - packed cursor y, channel i at [i*YW +: YW]
//   buttons   - packed {middle,right,left}, channel i at [i*3 +: 3]
//   click     - one-cycle pulse on left-button rising edge
//   pkt_valid - one-cycle pulse when a packet is accepted
//   err       - one-cycle pulse when a byte is discarded
module ps2_mouse_multi #(
    parameter int NUM_MICE       = 2,
    parameter int CANVAS_WIDTH   = 360,
    parameter int CANVAS_HEIGHT  = 720,
    parameter int X_INIT         = 180,
    parameter int Y_INIT         = 360,
    parameter int TIMEOUT_CYCLES = 200000,
    localparam int XW = $clog2(CANVAS_WIDTH),
    localparam int YW = $clog2(CANVAS_HEIGHT)
) (
    input  logic                   clk_in,
    input  logic                   rst_in,
    input  logic [NUM_MICE-1:0]    ps2_clk,
    input  logic [NUM_MICE-1:0]    ps2_data,
    output logic [NUM_MICE*XW-1:0] mouse_x,
    output logic [NUM_MICE*YW-1:0] mouse_y,
    output logic [NUM_MICE*3-1:0]  buttons,
    output logic [NUM_MICE-1:0]    click,
    output logic [NUM_MICE-1:0]    pkt_valid,
    output logic [NUM_MICE-1:0]    err
);
    // Working width: two guard bits above the wider axis so x+dx / y-dy never
    // wrap before the clamp; never narrower than a doubled 9-bit delta needs.
    localparam int MW = (XW > YW) ? XW : YW;
    localparam int AW = ((MW > 9) ? MW : 9) + 2;
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic signed [AW-1:0] XMAX = AW'(CANVAS_WIDTH - 1);
    localparam logic signed [AW-1:0] YMAX = AW'(CANVAS_HEIGHT - 1);

`ifdef MOUSE_ACCEL_EN
    localparam logic signed [AW-1:0] ACC_TH = AW'(8);
    function automatic logic signed [AW-1:0] f_accel(input logic signed [AW-1:0] d);
        if (d >= ACC_TH || d <= -ACC_TH) return d <<< 1;
        else return d;
    endfunction
`endif

    for (genvar i = 0; i < NUM_MICE; i++) begin : g_ch
        logic [1:0]           r_clk_s, r_dat_s;
        logic                 r_clk_d;
        logic [3:0]           r_bit_cnt;
        logic [8:0]           r_shift;     // data bits then parity, LSB first
        logic [1:0]           r_byte_idx;
        logic [TW-1:0]        r_timeout;
        logic [6:0]           r_hdr;       // {yovf,xovf,ysign,xsign,mid,right,left}
        logic [7:0]           r_b1;
        logic                 r_upd;
        logic signed [AW-1:0] r_dx, r_dy;
        logic [2:0]           r_btn_new;
        logic [XW-1:0]        r_x;
        logic [YW-1:0]        r_y;
        logic [2:0]           r_btn;
        logic                 r_click, r_pkt, r_err;

        logic                 w_fall, w_bit, w_frame_ok, w_upd;
        logic [7:0]           w_byte;
        logic signed [AW-1:0] w_dx_rx, w_dy_rx, w_dx, w_dy, w_xs, w_ys;
        logic [2:0]           w_btn;

        assign w_fall     = r_clk_d & ~r_clk_s[1];
        assign w_bit      = r_dat_s[1];
        assign w_byte     = r_shift[7:0];
        // Stop bit high and an odd number of ones across data plus parity.
        assign w_frame_ok = w_bit & (^r_shift);
        assign w_dx_rx    = r_hdr[5] ? '0 : $signed({{(AW-8){r_hdr[3]}}, r_b1});
        assign w_dy_rx    = r_hdr[6] ? '0 : $signed({{(AW-8){r_hdr[4]}}, w_byte});

        always_ff @(posedge clk_in) begin
            if (rst_in) begin
                r_clk_s    <= 2'b11;
                r_dat_s    <= 2'b11;
                r_clk_d    <= 1'b1;
                r_bit_cnt  <= '0;
                r_shift    <= '0;
                r_byte_idx <= '0;
                r_timeout  <= '0;
                r_hdr      <= '0;
                r_b1       <= '0;
                r_upd      <= 1'b0;
                r_dx       <= '0;
                r_dy       <= '0;
                r_btn_new  <= '0;
                r_err      <= 1'b0;
            end else begin
                r_clk_s <= {r_clk_s[0], ps2_clk[i]};
                r_dat_s <= {r_dat_s[0], ps2_data[i]};
                r_clk_d <= r_clk_s[1];
                r_upd   <= 1'b0;
                r_err   <= 1'b0;
                if (w_fall) begin
                    r_timeout <= '0;
                    if (r_bit_cnt == 4'd0) begin
                        // A high start bit is a discarded byte; stay hunting.
                        if (w_bit) begin
                            r_err      <= 1'b1;
                            r_byte_idx <= '0;
                        end else begin
                            r_bit_cnt <= 4'd1;
                        end
                    end else if (r_bit_cnt != 4'd10) begin
                        r_shift   <= {w_bit, r_shift[8:1]};
                        r_bit_cnt <= r_bit_cnt + 4'd1;
                    end else begin
                        r_bit_cnt <= '0;
                        if (!w_frame_ok) begin
                            r_err      <= 1'b1;
                            r_byte_idx <= '0;
                        end else begin
                            case (r_byte_idx)
                                2'd0: begin
                                    if (w_byte[3]) begin
                                        r_hdr      <= {w_byte[7:4], w_byte[2:0]};
                                        r_byte_idx <= 2'd1;
                                    end else begin
                                        r_err <= 1'b1;
                                    end
                                end
                                2'd1: begin
                                    r_b1       <= w_byte;
                                    r_byte_idx <= 2'd2;
                                end
                                default: begin
                                    r_byte_idx <= '0;
                                    r_upd      <= 1'b1;
                                    r_dx       <= w_dx_rx;
                                    r_dy       <= w_dy_rx;
                                    r_btn_new  <= r_hdr[2:0];
                                end
                            endcase
                        end
                    end
                end else if (r_timeout != TW'(TIMEOUT_CYCLES)) begin
                    r_timeout <= r_timeout + 1'b1;
                end else if (r_bit_cnt != 4'd0 || r_byte_idx != 2'd0) begin
                    r_bit_cnt  <= '0;
                    r_byte_idx <= '0;
                end
            end
        end

`ifdef MOUSE_ACCEL_EN
        logic                 r_upd_a;
        logic signed [AW-1:0] r_dx_a, r_dy_a;
        logic [2:0]           r_btn_a;
        always_ff @(posedge clk_in) begin
            if (rst_in) begin
                r_upd_a <= 1'b0;
                r_dx_a  <= '0;
                r_dy_a  <= '0;
                r_btn_a <= '0;
            end else begin
                r_upd_a <= r_upd;
                r_dx_a  <= f_accel(r_dx);
                r_dy_a  <= f_accel(r_dy);
                r_btn_a <= r_btn_new;
            end
        end
        assign w_upd = r_upd_a;
        assign w_dx  = r_dx_a;
        assign w_dy  = r_dy_a;
        assign w_btn = r_btn_a;
`else
        assign w_upd = r_upd;
        assign w_dx  = r_dx;
        assign w_dy  = r_dy;
        assign w_btn = r_btn_new;
`endif

        // PS/2 positive y is up, screen positive y is down.
        assign w_xs = $signed({{(AW-XW){1'b0}}, r_x}) + w_dx;
        assign w_ys = $signed({{(AW-YW){1'b0}}, r_y}) - w_dy;

        always_ff @(posedge clk_in) begin
            if (rst_in) begin
                r_x     <= XW'(X_INIT);
                r_y     <= YW'(Y_INIT);
                r_btn   <= '0;
                r_click <= 1'b0;
                r_pkt   <= 1'b0;
            end else begin
                r_pkt   <= w_upd;
                r_click <= w_upd & w_btn[0] & ~r_btn[0];
                if (w_upd) begin
                    r_btn <= w_btn;
                    if (w_xs[AW-1])     r_x <= '0;
                    else if (w_xs > XMAX) r_x <= XMAX[XW-1:0];
                    else                r_x <= w_xs[XW-1:0];
                    if (w_ys[AW-1])     r_y <= '0;
                    else if (w_ys > YMAX) r_y <= YMAX[YW-1:0];
                    else                r_y <= w_ys[YW-1:0];
                end
            end
        end

        assign mouse_x[i*XW +: XW] = r_x;
        assign mouse_y[i*YW +: YW] = r_y;
        assign buttons[i*3 +: 3]   = r_btn;
        assign click[i]            = r_click;
        assign pkt_valid[i]        = r_pkt;
        assign err[i]              = r_err;
    end
endmodule

// File: tb/tb_ps2_mouse_multi.sv
// tb/tb_ps2_mouse_multi.sv - directed bench with packet-level cursor model for ps2_mouse_multi
module tb_ps2_mouse_multi;
    localparam int N  = 2;
    localparam int TO = 2000;
    localparam int H  = 6;
`ifdef MOUSE_ACCEL_EN
    localparam int LAT = 5, T2X = 200, T3X = 0, T3Y = 719, ADX = 20;
`else
    localparam int LAT = 4, T2X = 190, T3X = 80, T3Y = 616, ADX = 10;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  pc, pd;
    logic [17:0] mouse_x;
    logic [19:0] mouse_y;
    logic [5:0]  buttons;
    logic [1:0]  click, pkt_valid, err;

    ps2_mouse_multi #(.NUM_MICE(N), .TIMEOUT_CYCLES(TO)) dut (
        .clk_in(clk), .rst_in(rst), .ps2_clk(pc), .ps2_data(pd),
        .mouse_x(mouse_x), .mouse_y(mouse_y), .buttons(buttons),
        .click(click), .pkt_valid(pkt_valid), .err(err));

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int nvec = 0, nfail = 0;
    function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
        nvec++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d",
                     name, act, act, exp, exp, cyc);
        end
    endfunction

    typedef struct {
        int         cyc;
        int         ch;
        logic [7:0] b0, b1, b2;
    } ev_t;
    ev_t q[$];

    // Model state: cursor and buttons per player, updated from whole packets.
    int mx[N] = '{180, 180};
    int my[N] = '{360, 360};
    int mb[N] = '{0, 0};
    int err_cnt[N] = '{0, 0};
    int ck_cnt[N]  = '{0, 0};

    function automatic int clampi(int v, int hi);
        if (v < 0) return 0;
        if (v > hi) return hi;
        return v;
    endfunction

    function automatic int delta(logic ovf, logic sgn, logic [7:0] mag);
        int d;
        d = ovf ? 0 : (sgn ? int'(mag) - 256 : int'(mag));
`ifdef MOUSE_ACCEL_EN
        if (d >= 8 || d <= -8) d = d * 2;
`endif
        return d;
    endfunction

    ev_t         ev;
    logic [17:0] ex;
    logic [19:0] ey;
    logic [5:0]  eb;
    logic [1:0]  epv, eck;

    always @(negedge clk) begin
        if (cyc >= 1) begin
            epv = '0;
            eck = '0;
            while (q.size() > 0 && q[0].cyc <= cyc) begin
                ev = q.pop_front();
                mx[ev.ch] = clampi(mx[ev.ch] + delta(ev.b0[6], ev.b0[4], ev.b1), 359);
                my[ev.ch] = clampi(my[ev.ch] - delta(ev.b0[7], ev.b0[5], ev.b2), 719);
                eck[ev.ch] = ev.b0[0] && !mb[ev.ch][0];
                mb[ev.ch] = int'(ev.b0[2:0]);
                epv[ev.ch] = 1'b1;
            end
            for (int c = 0; c < N; c++) begin
                ex[c*9 +: 9]  = 9'(mx[c]);
                ey[c*10 +: 10] = 10'(my[c]);
                eb[c*3 +: 3]  = 3'(mb[c]);
                err_cnt[c] += int'(err[c]);
                ck_cnt[c]  += int'(click[c]);
            end
            check("mouse_x", 64'(mouse_x), 64'(ex));
            check("mouse_y", 64'(mouse_y), 64'(ey));
            check("buttons", 64'(buttons), 64'(eb));
            check("pkt_valid", 64'(pkt_valid), 64'(epv));
            check("click", 64'(click), 64'(eck));
        end
    end

    task automatic tick(int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Sends one 11-bit frame on every channel in mask m; 'last' marks the
    // third byte of a good packet so the model learns when it must land.
    task automatic send_byte(input logic [1:0] m, input logic [7:0] b, input bit bad,
                             input bit last, input logic [7:0] h, input logic [7:0] xb);
        logic [10:0] fr;
        fr = {1'b1, (~^b) ^ bad, b, 1'b0};
        for (int k = 0; k < 11; k++) begin
            pd = (pd & ~m) | (m & {2{fr[k]}});
            tick(H);
            pc = pc & ~m;
            if (k == 10 && last)
                for (int c = 0; c < N; c++)
                    if (m[c]) q.push_back('{cyc + LAT, c, h, xb, b});
            tick(H);
            pc = pc | m;
        end
        tick(H);
    endtask

    task automatic send_pkt(input logic [1:0] m, input logic [7:0] b0,
                            input logic [7:0] b1, input logic [7:0] b2);
        send_byte(m, b0, 1'b0, 1'b0, 8'h00, 8'h00);
        send_byte(m, b1, 1'b0, 1'b0, 8'h00, 8'h00);
        send_byte(m, b2, 1'b0, 1'b1, b0, b1);
    endtask

    initial begin
        rst = 1'b1;
        pc  = 2'b11;
        pd  = 2'b11;
        tick(5);
        rst = 1'b0;
        tick(3);
        check("rst_x", 64'(mouse_x), 64'({9'd180, 9'd180}));
        check("rst_y", 64'(mouse_y), 64'({10'd360, 10'd360}));
        check("rst_pulses", 64'({buttons, click, pkt_valid, err}), 64'd0);

        send_pkt(2'b01, 8'h08, 8'h0A, 8'h05);
        check("t2_x0", 64'(mouse_x[8:0]), 64'(T2X));
        check("t2_y0", 64'(mouse_y[9:0]), 64'd355);
        check("t2_x1", 64'(mouse_x[17:9]), 64'd180);

        send_pkt(2'b10, 8'h39, 8'h9C, 8'h00);
        check("t3_x1", 64'(mouse_x[17:9]), 64'(T3X));
        check("t3_y1", 64'(mouse_y[19:10]), 64'(T3Y));
        check("t3_click", 64'(ck_cnt[1]), 64'd1);
        send_pkt(2'b10, 8'h39, 8'h9C, 8'h00);
        check("t3_noclick", 64'(ck_cnt[1]), 64'd1);
        check("t3_x1_floor", 64'(mouse_x[17:9]), 64'd0);
        check("t3_y1_ceil", 64'(mouse_y[19:10]), 64'd719);
        send_pkt(2'b10, 8'h08, 8'h0A, 8'h00);
        check("accel_dx", 64'(mouse_x[17:9]), 64'(ADX));

        send_pkt(2'b01, 8'h08, 8'hA0, 8'hFF);
        send_pkt(2'b01, 8'h08, 8'h32, 8'h5F);
`ifndef MOUSE_ACCEL_EN
        check("clamp_x", 64'(mouse_x[8:0]), 64'd359);
        check("pre_y", 64'(mouse_y[9:0]), 64'd5);
`endif
        send_pkt(2'b01, 8'h08, 8'h00, 8'h20);
        check("clamp_y", 64'(mouse_y[9:0]), 64'd0);

        send_byte(2'b01, 8'h08, 1'b0, 1'b0, 8'h00, 8'h00);
        send_byte(2'b01, 8'h0A, 1'b1, 1'b0, 8'h00, 8'h00);
        tick(20);
        check("parity_err", 64'(err_cnt[0]), 64'd1);
        send_pkt(2'b01, 8'h09, 8'hF6, 8'h01);

        send_byte(2'b01, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00);
        tick(20);
        check("align_err", 64'(err_cnt[0]), 64'd2);
        send_pkt(2'b01, 8'h08, 8'h03, 8'h03);

        send_byte(2'b10, 8'h08, 1'b0, 1'b0, 8'h00, 8'h00);
        send_byte(2'b10, 8'h05, 1'b0, 1'b0, 8'h00, 8'h00);
        tick(TO + 500);
        send_pkt(2'b10, 8'h08, 8'h03, 8'h00);
        check("timeout_no_err", 64'(err_cnt[1]), 64'd0);

        send_pkt(2'b11, 8'h0A, 8'h02, 8'h02);
        send_pkt(2'b11, 8'hC9, 8'h50, 8'h10);
        check("ovf_btn", 64'(buttons), 64'({3'b001, 3'b001}));

        tick(20);
        check("queue_drained", 64'(q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end
endmodule

// File: doc/ps2_mouse_multi.md
Name: ps2_mouse_multi

Overview:
- Parametrised successor to the single-mouse interface.
- Receives PS/2 streams from NUM_MICE independent mice, one per player, on one clock.
- Per channel: decodes 3-byte standard packets, accumulates a cursor clamped to the canvas, and reports button state and click pulses.
- Feeds per-player cursor position and click to the processor and graphics blocks.

Parameters:
- NUM_MICE, 2, number of independent PS/2 channels (1..4).
- CANVAS_WIDTH, 360, x range is 0..CANVAS_WIDTH-1.
- CANVAS_HEIGHT, 720, y range is 0..CANVAS_HEIGHT-1.
- X_INIT, 180, cursor x after reset.
- Y_INIT, 360, cursor y after reset.
- TIMEOUT_CYCLES, 200000, idle clk_in cycles mid-packet before resync (2 ms at 100 MHz).
- Derived: XW=$clog2(CANVAS_WIDTH), YW=$clog2(CANVAS_HEIGHT).

Ports:
- clk_in  input  1  system clock (100 MHz buffered).
- rst_in  input  1  synchronous active-high reset.
- ps2_clk  input  NUM_MICE  raw PS/2 clock per channel (asynchronous).
- ps2_data  input  NUM_MICE  raw PS/2 data per channel (asynchronous).
- mouse_x  output  NUM_MICE*XW  packed cursor x; channel i at [i*XW +: XW].
- mouse_y  output  NUM_MICE*YW  packed cursor y; channel i at [i*YW +: YW].
- buttons  output  NUM_MICE*3  {middle,right,left} from last accepted packet.
- click  output  NUM_MICE  one-cycle pulse on rising edge of left button.
- pkt_valid  output  NUM_MICE  one-cycle pulse when a packet is accepted.
- err  output  NUM_MICE  one-cycle pulse on a discarded byte (parity, start, stop, or alignment failure).

Behaviour:
- Reset (synchronous, active-high):
  - mouse_x=X_INIT, mouse_y=Y_INIT.
  - buttons, click, pkt_valid, err = 0.
  - Bit counter, byte index and timeout counter = 0.
  - rst_in asserted mid-frame aborts the frame; no partial update.
- Channels are fully independent, with identical logic generated per channel.
- Input conditioning: 2-FF synchroniser on ps2_clk and ps2_data, then a falling-edge detect on the synchronised clock. Data is sampled on the detect cycle.
- Frame reception, 11 bits:
  - Start bit = 0, 8 data bits LSB first, odd parity, stop bit = 1.
  - Bit counter runs 0..10 and wraps to 0 after the stop bit.
  - If start≠0, stop≠1 or parity is even: discard the byte, pulse err, reset byte index to 0.
- Packet assembly, byte index 0..2:
  - Byte0 = {yovf,xovf,ysign,xsign,1,mid,right,left}.
  - Byte0 with bit3=0 is rejected as misaligned: pulse err, index stays 0.
  - Bytes 1 and 2 are X and Y magnitude LSBs.
- Timeout: timeout counter clears on every falling edge and counts otherwise. When it reaches TIMEOUT_CYCLES while bit counter≠0 or byte index≠0, both are cleared. Timeout does not pulse err.
- Delta formation:
  - dx = signed 9-bit {xsign,byte1}; dy = signed 9-bit {ysign,byte2}.
  - If xovf is set, dx=0; if yovf is set, dy=0. Buttons still update.
- Position update, in the cycle after the third byte's stop bit is sampled:
  - x_new = clamp(x+dx, 0, CANVAS_WIDTH-1).
  - y_new = clamp(y-dy, 0, CANVAS_HEIGHT-1). PS/2 +y means up; screen +y means down.
  - Arithmetic is signed, width max(XW,YW)+2, so no wrap before the clamp.
- Output timing (same cycle as the position update):
  - mouse_x/mouse_y/buttons are registered and change in that cycle; pkt_valid pulses.
  - click pulses if new left=1 and the previous left=0.
  - Holding left across packets yields no further pulses.
- Latency: stop-bit falling edge at the pins → outputs updated 4 clk_in cycles later (2 synchroniser stages, 1 edge detect, 1 update).
- Simultaneous packets on different channels update in the same cycle with no interaction.

Optional Feature:
- Macro: MOUSE_ACCEL_EN.
- Defined: any delta with |d| ≥ 8 is doubled (arithmetic shift left 1) before the clamp; smaller deltas pass unchanged. Adds one pipeline register, so output latency is 5 cycles.
- Undefined: deltas are used as received; latency is 4 cycles.

Test Plan:
- Reset release → mouse_x=180, mouse_y=360, all pulse outputs 0, buttons=0.
- Channel 0 packet {0x08,0x0A,0x05} → x=190, y=355, pkt_valid[0] 1 cycle, channel 1 unchanged.
- Packet {0x39,0x9C,0x00}: left pressed, dx=-100 → pkt_valid, click pulse once; x=80 from 180. Repeat with the same left state → no click.
- Clamp: from x=350, dx=+50 → x=359. From y=5, packet {0x08,0x00,0x20} (dy=+32) → y=0.
- Parity error injected in byte1 → err pulse, byte index resets, no update. Next good packet is accepted normally.
- Two bytes sent, then 250000 idle cycles, then a full packet → only the full packet applied. With MOUSE_ACCEL_EN, dx=+10 → x advances by 20.
